// File: rtl/cache_sim_pkg.sv
// Shared constants and FSM state type for the multicore cache simulator
// refill path.
package cache_sim_pkg;
    localparam int NUM_CORES         = 4;
    localparam int ADDR_W            = 16;
    localparam int BLOCK_OFFSET_BITS = 6;
    localparam int BLOCK_BYTES       = 2 ** BLOCK_OFFSET_BITS;
    localparam int DATA_W            = 8;
    localparam int RAM_LATENCY       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } refill_state_e;
endpackage

// File: rtl/refill_arbiter_rr_arbiter.sv
// Round-robin picker: combinational one-hot choice starting at the priority
// pointer, pointer advanced past the winner on each grant strobe.
module rr_arbiter
    import cache_sim_pkg::*;
#(
    parameter int N     = NUM_CORES,
    parameter int PTR_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             gnt_en,
    output logic [N-1:0]     gnt_onehot,
    output logic [PTR_W-1:0] gnt_idx
);
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;
    int               idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        idx        = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && req[idx]) begin
                found           = 1'b1;
                gnt_idx         = PTR_W'(idx);
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_en) begin
            ptr_d = (int'(gnt_idx) == N - 1) ? '0 : PTR_W'(int'(gnt_idx) + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/refill_arbiter.sv
// Grants one core at a time and streams its whole cache line out of block
// RAM one byte per cycle, tagging returns through a latency-matched pipe.
module refill_arbiter
    import cache_sim_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CORES-1:0]            req,
    input  logic [NUM_CORES*ADDR_W-1:0]     req_addr,
    output logic [NUM_CORES-1:0]            gnt,
    output logic                            ram_en,
    output logic [ADDR_W-1:0]               ram_addr,
    input  logic [DATA_W-1:0]               ram_rdata,
    output logic [NUM_CORES-1:0]            fill_valid,
    output logic [DATA_W-1:0]               fill_data,
    output logic [BLOCK_OFFSET_BITS-1:0]    fill_offset,
    output logic [NUM_CORES-1:0]            fill_done,
    output logic                            busy
);
    localparam int PTR_W = $clog2(NUM_CORES);
    localparam int CNT_W = BLOCK_OFFSET_BITS;
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BLOCK_BYTES - 1);

    refill_state_e          state_q, state_d;
    logic [NUM_CORES-1:0]   gnt_q, gnt_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [CNT_W-1:0]       issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]       fill_offset_q, fill_offset_d;
    logic                   ram_en_q, ram_en_d;
    logic [ADDR_W-1:0]      ram_addr_q, ram_addr_d;
    logic [RAM_LATENCY-1:0] pipe_q, pipe_d;

    logic [ADDR_W-1:0]      addr_arr [NUM_CORES];
    logic [NUM_CORES-1:0]   win_onehot;
    logic [PTR_W-1:0]       win_idx;
    logic                   grant_en;
    logic                   ret_valid;
    logic                   last_ret;

    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_addr
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    rr_arbiter #(.N(NUM_CORES), .PTR_W(PTR_W)) u_rr (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt_en     (grant_en),
        .gnt_onehot (win_onehot),
        .gnt_idx    (win_idx)
    );

    assign ret_valid = pipe_q[RAM_LATENCY-1];
    assign last_ret  = ret_valid && (&fill_offset_q);

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        base_d        = base_q;
        issue_cnt_d   = issue_cnt_q;
        ram_en_d      = ram_en_q;
        ram_addr_d    = ram_addr_q;
        grant_en      = 1'b0;
        fill_offset_d = ret_valid ? fill_offset_q + 1'b1 : fill_offset_q;

        // Each stage carries one issue tag; the tail lines up with ram_rdata.
        pipe_d[0] = ram_en_q;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_en    = 1'b1;
                    gnt_d       = win_onehot;
                    base_d      = addr_arr[win_idx] & ~LINE_MASK;
                    issue_cnt_d = '0;
                    ram_en_d    = 1'b1;
                    ram_addr_d  = base_d;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (&issue_cnt_q) begin
                    ram_en_d   = 1'b0;
                    ram_addr_d = '0;
                    state_d    = DRAIN;
                end else begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    ram_addr_d  = base_q | ADDR_W'(issue_cnt_d);
                end
            end
            DRAIN: begin
                if (last_ret) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            base_q        <= '0;
            issue_cnt_q   <= '0;
            fill_offset_q <= '0;
            ram_en_q      <= 1'b0;
            ram_addr_q    <= '0;
            pipe_q        <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            base_q        <= base_d;
            issue_cnt_q   <= issue_cnt_d;
            fill_offset_q <= fill_offset_d;
            ram_en_q      <= ram_en_d;
            ram_addr_q    <= ram_addr_d;
            pipe_q        <= pipe_d;
        end
    end

    assign gnt         = gnt_q;
    assign ram_en      = ram_en_q;
    assign ram_addr    = ram_addr_q;
    assign fill_valid  = ret_valid ? gnt_q : '0;
    assign fill_data   = ret_valid ? ram_rdata : '0;
    assign fill_offset = fill_offset_q;
    assign fill_done   = last_ret ? gnt_q : '0;
    assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_refill_arbiter.sv
// Randomized bench for refill_arbiter with a 3-cycle block RAM model and a
// transaction-level round-robin reference.
module tb_refill_arbiter;
    import cache_sim_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] req_addr = '0;
    logic [3:0]  gnt;
    logic        ram_en;
    logic [15:0] ram_addr;
    logic [7:0]  ram_rdata;
    logic [3:0]  fill_valid;
    logic [7:0]  fill_data;
    logic [5:0]  fill_offset;
    logic [3:0]  fill_done;
    logic        busy;

    refill_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .gnt(gnt),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .fill_valid(fill_valid), .fill_data(fill_data), .fill_offset(fill_offset),
        .fill_done(fill_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    // Block RAM model: data for the address presented in cycle k shows up in cycle k+3.
    logic [15:0] pa0 = '0, pa1 = '0, pa2 = '0;
    always @(posedge clk) begin
        pa0 <= ram_addr;
        pa1 <= pa0;
        pa2 <= pa1;
    end
    assign ram_rdata = mem_byte(pa2);

    int total = 0;
    int bad = 0;
    int ptr_m = 0;

    logic [15:0] iss_addr [64];
    logic [5:0]  f_off [64];
    logic [7:0]  f_dat [64];
    logic [3:0]  f_vld [64];
    int   n_iss, n_fill, g_cyc, d_cyc, f1_cyc, fill_at_done;
    logic [3:0] cap_gnt, cap_done, gnt_after;
    logic busy_after, gnt_unstable, timed_out;
    int   drop_core = -1;
    int   drop_at = -1;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [15:0] line_base(input int c);
        logic [15:0] a;
        a = req_addr[c*16 +: 16];
        return {a[15:6], 6'd0};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        @(negedge clk);
    endtask

    // Records one complete transaction; scrambles every req_addr after the 5th issue.
    task automatic capture_txn();
        int t;
        n_iss = 0; n_fill = 0; gnt_unstable = 0; timed_out = 0;
        cap_done = '0; fill_at_done = 0; f1_cyc = 0; d_cyc = 0; cap_gnt = '0;
        t = 0;
        while (gnt === 4'b0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (gnt === 4'b0) begin
            timed_out = 1;
            return;
        end
        cap_gnt = gnt;
        g_cyc = cyc;
        t = 0;
        while (t < 300) begin
            if (gnt !== cap_gnt) gnt_unstable = 1;
            if (ram_en === 1'b1) begin
                if (n_iss < 64) iss_addr[n_iss] = ram_addr;
                n_iss++;
                if (n_iss == 5) req_addr = {$urandom, $urandom};
                if (drop_core >= 0 && n_iss == drop_at) req[drop_core] = 1'b0;
            end
            if (fill_valid !== 4'b0) begin
                if (n_fill == 0) f1_cyc = cyc;
                if (n_fill < 64) begin
                    f_off[n_fill] = fill_offset;
                    f_dat[n_fill] = fill_data;
                    f_vld[n_fill] = fill_valid;
                end
                n_fill++;
            end
            if (fill_done !== 4'b0) begin
                cap_done = fill_done;
                d_cyc = cyc;
                fill_at_done = n_fill;
                break;
            end
            @(negedge clk);
            t++;
        end
        if (cap_done === 4'b0) timed_out = 1;
        @(negedge clk);
        busy_after = busy;
        gnt_after = gnt;
        $display("txn gnt=%b first_addr=%h issues=%0d fills=%0d done=%b cycles=%0d",
                 cap_gnt, iss_addr[0], n_iss, n_fill, cap_done, d_cyc - g_cyc + 1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b1111;
        req_addr = 64'h1234_5678_9ABC_DEF0;
        repeat (3) @(negedge clk);
        total++; if (gnt !== 4'b0) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
        total++; if (ram_en !== 1'b0 || ram_addr !== 16'h0) begin bad++; $display("FAIL reset_ram got en=%b addr=%h want 0/0000", ram_en, ram_addr); end
        total++; if (fill_valid !== 4'b0 || fill_done !== 4'b0 || fill_offset !== 6'd0) begin
            bad++; $display("FAIL reset_fill got vld=%b done=%b off=%0d want zeros", fill_valid, fill_done, fill_offset); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        req = '0;
        rst_n = 1'b1;
        ptr_m = 0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int c, e;
        logic [15:0] eb;
        do_reset();
        req_addr[15:0] = 16'h0009;
        req = 4'b0001;
        c = pick(req, ptr_m);
        eb = line_base(c);
        capture_txn();
        req = '0;
        ptr_m = (c + 1) % 4;
        total++; if (timed_out) begin bad++; $display("FAIL single_timeout got=timeout want=done"); end
        total++; if (cap_gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b want=0001", cap_gnt); end
        total++; if (n_iss != 64 || n_fill != 64) begin bad++; $display("FAIL single_counts got iss=%0d fill=%0d want 64/64", n_iss, n_fill); end
        e = 0;
        for (int i = 0; i < 64 && i < n_fill && i < n_iss; i++) begin
            if (iss_addr[i] !== 16'(i) || f_off[i] !== 6'(i) || f_dat[i] !== mem_byte(eb + 16'(i)) || f_vld[i] !== 4'b0001) begin
                if (e == 0) $display("FAIL single_stream idx=%0d got addr=%h off=%0d dat=%h vld=%b want addr=%h off=%0d dat=%h vld=0001",
                                     i, iss_addr[i], f_off[i], f_dat[i], f_vld[i], 16'(i), i, mem_byte(eb + 16'(i)));
                e++;
            end
        end
        total++; if (e != 0) bad++;
        total++; if (f1_cyc - g_cyc != 3) begin bad++; $display("FAIL single_latency got=%0d want=3", f1_cyc - g_cyc); end
        total++; if (d_cyc - g_cyc + 1 != 67) begin bad++; $display("FAIL single_done_cycle got=%0d want=67", d_cyc - g_cyc + 1); end
        total++; if (cap_done !== 4'b0001 || fill_at_done != 64) begin bad++; $display("FAIL single_done got=%b at_fill=%0d want 0001 at 64", cap_done, fill_at_done); end
        total++; if (busy_after !== 1'b0 || gnt_after !== 4'b0 || gnt_unstable) begin
            bad++; $display("FAIL single_release got busy=%b gnt=%b unstable=%0d want 0/0000/0", busy_after, gnt_after, gnt_unstable); end
    endtask

    task automatic test_pair();
        int c, e, prev_done;
        logic [15:0] eb;
        do_reset();
        req_addr = {$urandom, $urandom};
        req = 4'b0110;
        for (int n = 0; n < 2; n++) begin
            c = pick(req, ptr_m);
            eb = line_base(c);
            capture_txn();
            req[c] = 1'b0;
            ptr_m = (c + 1) % 4;
            total++; if (timed_out || cap_gnt !== 4'(1 << (n + 1))) begin
                bad++; $display("FAIL pair_order n=%0d got=%b want=%b", n, cap_gnt, 4'(1 << (n + 1))); end
            e = 0;
            for (int i = 0; i < 64 && i < n_fill && i < n_iss; i++) begin
                if (iss_addr[i] !== eb + 16'(i) || f_dat[i] !== mem_byte(eb + 16'(i)) || f_off[i] !== 6'(i)) e++;
            end
            total++; if (e != 0 || n_fill != 64) begin bad++; $display("FAIL pair_stream n=%0d got errs=%0d fills=%0d want 0/64", n, e, n_fill); end
            if (n == 1) begin
                total++; if (g_cyc - prev_done != 2) begin bad++; $display("FAIL pair_gap got=%0d want=2", g_cyc - prev_done); end
            end
            prev_done = d_cyc;
        end
    endtask

    task automatic test_round_robin();
        int c, e;
        logic [15:0] eb;
        do_reset();
        req_addr = {$urandom, $urandom};
        req = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            c = pick(req, ptr_m);
            eb = line_base(c);
            capture_txn();
            ptr_m = (c + 1) % 4;
            total++; if (timed_out || cap_gnt !== 4'(1 << (n % 4))) begin
                bad++; $display("FAIL rr_order n=%0d got=%b want=%b", n, cap_gnt, 4'(1 << (n % 4))); end
            e = 0;
            for (int i = 0; i < 64 && i < n_fill && i < n_iss; i++) begin
                if (iss_addr[i] !== eb + 16'(i) || f_dat[i] !== mem_byte(eb + 16'(i)) || f_vld[i] !== 4'(1 << c)) e++;
            end
            total++; if (e != 0 || n_fill != 64 || cap_done !== 4'(1 << c)) begin
                bad++; $display("FAIL rr_stream n=%0d got errs=%0d fills=%0d done=%b want 0/64/%b", n, e, n_fill, cap_done, 4'(1 << c)); end
        end
        req = '0;
    endtask

    task automatic test_drop();
        int e;
        do_reset();
        req_addr[63:48] = 16'h0045;
        req = 4'b1000;
        drop_core = 3;
        drop_at = 10;
        capture_txn();
        drop_core = -1;
        total++; if (cap_gnt !== 4'b1000) begin bad++; $display("FAIL drop_gnt got=%b want=1000", cap_gnt); end
        e = 0;
        for (int i = 0; i < 64 && i < n_fill && i < n_iss; i++) begin
            if (iss_addr[i] !== 16'h0040 + 16'(i) || f_dat[i] !== mem_byte(16'h0040 + 16'(i)) || f_off[i] !== 6'(i)) e++;
        end
        total++; if (e != 0 || n_fill != 64 || n_iss != 64) begin
            bad++; $display("FAIL drop_stream got errs=%0d fills=%0d issues=%0d want 0/64/64", e, n_fill, n_iss); end
        total++; if (cap_done !== 4'b1000) begin bad++; $display("FAIL drop_done got=%b want=1000", cap_done); end
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_idle got busy=%b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        int cnt, t;
        logic saw_done;
        do_reset();
        req_addr = {$urandom, $urandom};
        req = 4'b0100;
        cnt = 0; t = 0; saw_done = 0;
        while (cnt < 30 && t < 300) begin
            @(negedge clk);
            t++;
            if (ram_en === 1'b1) cnt++;
        end
        total++; if (cnt != 30) begin bad++; $display("FAIL midrst_issues got=%0d want=30", cnt); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (gnt !== 4'b0 || ram_en !== 1'b0 || ram_addr !== 16'h0 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst_outputs got gnt=%b en=%b addr=%h busy=%b want zeros", gnt, ram_en, ram_addr, busy); end
        total++; if (fill_valid !== 4'b0 || fill_done !== 4'b0 || fill_data !== 8'h0 || fill_offset !== 6'd0) begin
            bad++; $display("FAIL midrst_fill got vld=%b done=%b data=%h off=%0d want zeros", fill_valid, fill_done, fill_data, fill_offset); end
        req = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (fill_done !== 4'b0) saw_done = 1;
        end
        rst_n = 1'b1;
        ptr_m = 0;
        capture_txn();
        req = '0;
        total++; if (saw_done || timed_out || cap_gnt !== 4'(1 << pick(4'b0110, 0))) begin
            bad++; $display("FAIL midrst_regrant got gnt=%b done_seen=%0d want=0010", cap_gnt, saw_done); end
        ptr_m = 2;
    endtask

    task automatic test_random();
        int c, e;
        logic [15:0] eb;
        do_reset();
        req_addr = {$urandom, $urandom};
        req = 4'($urandom_range(1, 15));
        for (int n = 0; n < 6; n++) begin
            c = pick(req, ptr_m);
            eb = line_base(c);
            capture_txn();
            ptr_m = (c + 1) % 4;
            total++; if (timed_out || cap_gnt !== 4'(1 << c)) begin
                bad++; $display("FAIL rand_gnt n=%0d got=%b want=%b", n, cap_gnt, 4'(1 << c)); end
            e = 0;
            for (int i = 0; i < 64 && i < n_fill && i < n_iss; i++) begin
                if (iss_addr[i] !== eb + 16'(i) || f_dat[i] !== mem_byte(eb + 16'(i)) || f_off[i] !== 6'(i)) e++;
            end
            total++; if (e != 0 || n_fill != 64 || d_cyc - g_cyc != 66 || cap_done !== 4'(1 << c)) begin
                bad++; $display("FAIL rand_stream n=%0d got errs=%0d fills=%0d span=%0d done=%b want 0/64/66/%b",
                                n, e, n_fill, d_cyc - g_cyc, cap_done, 4'(1 << c)); end
            req[c] = 1'b0;
            req = req | 4'($urandom_range(0, 15));
            if (req == 4'b0) req = 4'($urandom_range(1, 15));
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_pair();
        test_round_robin();
        test_drop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
